// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side handshake and memory-port signals for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]         resp_data;
  logic                          mem_en;
  logic                          mem_we;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_wdata;
  logic [DATA_WIDTH-1:0]         mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_data, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_data, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one registered-read BRAM port among NUM_REQ
// single-beat requesters. Grant is combinational; read responses come back
// one cycle after accept, tagged with a one-hot valid.
module mem_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] grant_p0;
  logic               gnt_any_p0;
  int                 gnt_idx_p0;
  int                 scan_idx;
  logic [NUM_REQ-1:0] resp_vld_p1;

  // Pointer to the requester after idx, wrapping at NUM_REQ.
  function automatic logic [PTR_W-1:0] next_ptr(input int idx);
    if (idx >= NUM_REQ - 1) return '0;
    return PTR_W'(idx + 1);
  endfunction

  // Stage p0: scan from rr_ptr for the first valid requester and route it to memory.
  always_comb begin
    grant_p0      = '0;
    gnt_any_p0    = 1'b0;
    gnt_idx_p0    = 0;
    scan_idx      = 0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (!rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
        if (!gnt_any_p0 && bus.req_valid[scan_idx]) begin
          gnt_any_p0         = 1'b1;
          gnt_idx_p0         = scan_idx;
          grant_p0[scan_idx] = 1'b1;
          bus.mem_we         = bus.req_we[scan_idx];
          bus.mem_addr       = bus.req_addr[scan_idx*ADDR_WIDTH +: ADDR_WIDTH];
          bus.mem_wdata      = bus.req_wdata[scan_idx*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign bus.req_ready = grant_p0;
  assign bus.mem_en    = gnt_any_p0;

  // Stage p1: advance the round-robin pointer past the winner and tag read responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      resp_vld_p1 <= '0;
    end else begin
      if (gnt_any_p0) rr_ptr <= next_ptr(gnt_idx_p0);
      resp_vld_p1 <= bus.mem_we ? '0 : grant_p0;
    end
  end

  // A response whose cycle coincides with reset is dropped rather than delivered.
  assign bus.resp_valid = rst ? '0 : resp_vld_p1;
  assign bus.resp_data  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter with a behavioural BRAM,
// a shadow-memory reference model and a response scoreboard.
module tb_mem_port_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 8;

  typedef struct {
    int             due;
    logic [N-1:0]   oh;
    logic [DW-1:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;

  mem_port_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif ();

  mem_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural BRAM port: registered read, one operation per enabled cycle.
  logic [DW-1:0] bram [256];
  always @(posedge clk) begin
    if (bif.mem_en) begin
      if (bif.mem_we) bram[bif.mem_addr] <= bif.mem_wdata;
      else            bif.mem_rdata <= bram[bif.mem_addr];
    end
  end

  // Reference state
  logic [DW-1:0] shadow [256];
  int            ptr = 0;
  exp_t          q[$];

  // Requester intentions
  logic          r_vld  [N];
  logic          r_we   [N];
  logic [AW-1:0] r_addr [N];
  logic [DW-1:0] r_wd   [N];

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bif.req_valid[i]           = r_vld[i];
      bif.req_we[i]              = r_we[i];
      bif.req_addr[i*AW +: AW]   = r_addr[i];
      bif.req_wdata[i*DW +: DW]  = r_wd[i];
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      r_vld[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = '0; r_wd[i] = '0;
    end
  endtask

  // Predict the grant from the round-robin rule, compare, and update the model.
  task automatic check_cycle(output int g);
    logic [N-1:0] eg;
    int i;
    g  = -1;
    eg = '0;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        i = (ptr + k) % N;
        if (g < 0 && r_vld[i]) g = i;
      end
    end
    if (g >= 0) eg[g] = 1'b1;
    vectors++;
    if (bif.req_ready !== eg || bif.mem_en !== (g >= 0)) begin
      miscompares++;
      $display("FAIL grant cyc=%0d: ready=%b en=%b, expected ready=%b en=%b",
               cyc, bif.req_ready, bif.mem_en, eg, (g >= 0));
    end
    vectors++;
    if (g >= 0) begin
      if (bif.mem_we !== r_we[g] || bif.mem_addr !== r_addr[g] ||
          (r_we[g] && bif.mem_wdata !== r_wd[g])) begin
        miscompares++;
        $display("FAIL memdrive cyc=%0d: we=%b addr=%h wd=%h, expected we=%b addr=%h wd=%h",
                 cyc, bif.mem_we, bif.mem_addr, bif.mem_wdata, r_we[g], r_addr[g], r_wd[g]);
      end
    end else if (bif.mem_we !== 1'b0 || bif.mem_addr !== '0 || bif.mem_wdata !== '0) begin
      miscompares++;
      $display("FAIL memidle cyc=%0d: we=%b addr=%h wd=%h, expected all zero",
               cyc, bif.mem_we, bif.mem_addr, bif.mem_wdata);
    end
    if (rst) begin
      ptr = 0;
    end else if (g >= 0) begin
      ptr = (g + 1) % N;
      if (r_we[g]) shadow[r_addr[g]] = r_wd[g];
      else         q.push_back('{cyc + 1, eg, shadow[r_addr[g]]});
    end
  endtask

  task automatic next_cycle(output int g);
    @(negedge clk);
    check_cycle(g);
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every cycle the expected response (or silence) is compared.
  always @(negedge clk) begin : monitor
    exp_t          e;
    logic [N-1:0]  e_oh;
    logic [DW-1:0] e_d;
    if (mon_en) begin
      e_oh = '0;
      e_d  = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        if (!rst) begin
          e_oh = e.oh;
          e_d  = e.data;
        end
      end
      vectors++;
      if (bif.resp_valid !== e_oh) begin
        miscompares++;
        $display("FAIL resp_valid cyc=%0d: got %b, expected %b", cyc, bif.resp_valid, e_oh);
      end
      if (e_oh != '0) begin
        vectors++;
        if (bif.resp_data !== e_d) begin
          miscompares++;
          $display("FAIL resp_data cyc=%0d: got %h, expected %h", cyc, bif.resp_data, e_d);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int g;
    for (int a = 0; a < 256; a++) begin
      bram[a]   = '0;
      shadow[a] = '0;
    end
    // Reset with every requester asserting a read.
    clear_reqs();
    for (int i = 0; i < N; i++) begin r_vld[i] = 1'b1; r_addr[i] = AW'(i); end
    rst = 1'b1;
    apply();
    @(posedge clk); #1;
    mon_en = 1'b1;
    for (int c = 0; c < 5; c++) next_cycle(g);
    rst = 1'b0;
    next_cycle(g);

    // Requester 2 writes then reads the same address.
    clear_reqs();
    r_vld[2] = 1'b1; r_we[2] = 1'b1; r_addr[2] = 8'h10; r_wd[2] = 8'hA5;
    apply(); next_cycle(g);
    r_we[2] = 1'b0;
    apply(); next_cycle(g);
    clear_reqs(); apply(); next_cycle(g);

    // Pre-write 0x00..0x03 through requester 3, then all four read for 8 cycles.
    for (int a = 0; a < 4; a++) begin
      r_vld[3] = 1'b1; r_we[3] = 1'b1; r_addr[3] = AW'(a); r_wd[3] = DW'(8'h30 + a);
      apply(); next_cycle(g);
    end
    clear_reqs();
    for (int i = 0; i < N; i++) begin r_vld[i] = 1'b1; r_addr[i] = AW'(i); end
    apply();
    for (int c = 0; c < 8; c++) next_cycle(g);

    // Pointer skip with requesters 1 and 3, then requester 0 joins.
    clear_reqs();
    r_vld[1] = 1'b1; r_addr[1] = 8'h01;
    r_vld[3] = 1'b1; r_addr[3] = 8'h03;
    apply();
    for (int c = 0; c < 4; c++) next_cycle(g);
    r_vld[0] = 1'b1; r_addr[0] = 8'h00;
    apply();
    for (int c = 0; c < 3; c++) next_cycle(g);

    // Streaming: requester 0 writes data=addr, then reads everything back.
    clear_reqs();
    r_vld[0] = 1'b1; r_we[0] = 1'b1;
    for (int a = 0; a < 255; a++) begin
      r_addr[0] = AW'(a); r_wd[0] = DW'(a);
      apply(); next_cycle(g);
    end
    r_we[0] = 1'b0;
    for (int a = 0; a < 255; a++) begin
      r_addr[0] = AW'(a);
      apply(); next_cycle(g);
    end

    // Reset right after a read accept by requester 1.
    clear_reqs();
    r_vld[1] = 1'b1; r_addr[1] = 8'h20;
    apply(); next_cycle(g);
    clear_reqs(); rst = 1'b1;
    apply(); next_cycle(g); next_cycle(g);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin r_vld[i] = 1'b1; r_addr[i] = AW'(8'h40 + i); end
    apply();
    for (int c = 0; c < 4; c++) next_cycle(g);

    // Random traffic obeying the hold-while-pending contract, with rare resets.
    clear_reqs(); apply(); next_cycle(g);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ((r_vld[i] && g == i) || !r_vld[i]) begin
          r_vld[i] = ($urandom_range(0, 99) < 60);
          if (r_vld[i]) begin
            r_we[i]   = $urandom_range(0, 1) == 1;
            r_addr[i] = AW'($urandom_range(0, 15));
            r_wd[i]   = DW'($urandom_range(0, 255));
          end
        end else if ($urandom_range(0, 99) < 5) begin
          r_vld[i] = 1'b0;
        end
      end
      rst = ($urandom_range(0, 99) < 2);
      apply();
      next_cycle(g);
    end
    rst = 1'b0;
    clear_reqs(); apply();
    for (int c = 0; c < 3; c++) next_cycle(g);

    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Round-robin arbiter that shares one port of the team's dual-port BRAM model (registered read, 1-cycle latency, read-or-write per enabled cycle) among NUM_REQ requesters. Each requester issues single-beat read/write requests over a valid/ready handshake. Read data returns on a shared bus tagged with a one-hot response valid. The block sits between client engines (DMA, scrubber, CPU shim) and memory port A or B.

Parameters:
NUM_REQ, 4, number of requesters (>=1)
DATA_WIDTH, 8, memory word width
ADDR_WIDTH, 8, memory address width

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  reset
req_valid  in  NUM_REQ  per-requester request valid
req_we  in  NUM_REQ  per-requester 1=write, 0=read
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
req_ready  out  NUM_REQ  one-hot grant; request i accepted at edge where req_valid[i]&&req_ready[i]
resp_valid  out  NUM_REQ  one-hot; read data for requester i valid this cycle
resp_data  out  DATA_WIDTH  read data, broadcast to all requesters
mem_en  out  1  to memory en
mem_we  out  1  to memory we
mem_addr  out  ADDR_WIDTH  to memory address
mem_wdata  out  DATA_WIDTH  to memory write data
mem_rdata  in  DATA_WIDTH  from memory registered read output

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- State: rr_ptr (clog2(NUM_REQ) bits, 0 when NUM_REQ=1), resp_valid register (NUM_REQ bits).
- Grant (combinational): scan indices rr_ptr, rr_ptr+1, ... mod NUM_REQ. The first i with req_valid[i]=1 gets req_ready[i]=1. All other ready bits are 0. No request valid -> req_ready=0.
- Ready does not depend on ready; there is no backpressure from memory. A granted request is always accepted the same cycle.
- Memory drive (combinational): mem_en = |req_ready. mem_we, mem_addr and mem_wdata come from the granted requester. When idle, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Pointer update at each accept of requester i: rr_ptr <= (i+1) mod NUM_REQ. No accept -> rr_ptr holds. With all requesters continuously valid, grant order is 0,1,2,...,NUM_REQ-1,0.
- Read latency: read accepted at edge k -> resp_valid[i]=1 for exactly the cycle after edge k. resp_data = mem_rdata, which the memory updated at edge k.
- Writes produce no response: resp_valid register <= 0 for a write accept.
- Back-to-back: one accept per cycle max. A lone requester may issue a read or write every cycle, and reads stream one response per cycle.
- Write then read to the same address in consecutive cycles returns the new data.
- resp_data when no resp_valid: passes mem_rdata (don't-care for clients).
- Requester contract: req_addr, req_wdata and req_we must be held stable while req_valid=1 and not accepted. Dropping valid before accept is permitted; the arbiter keeps no memory of it.
- Reset (rst=1 at an edge): rr_ptr <= 0, resp_valid <= 0.
- While rst=1: req_ready=0 and mem_en=0, regardless of req_valid.
- Reset mid-operation: a read accepted on the edge before rst asserts still yields its response in the following cycle unless rst is high at that edge, in which case the response is dropped. No response is produced for requests presented during reset.
- NUM_REQ=1: degenerates to pass-through with the ready gated only by rst.

Test Plan:
- Reset: hold rst 5 cycles with req_valid=4'b1111 -> req_ready=0, mem_en=0, resp_valid=0 throughout. First post-reset grant goes to requester 0.
- Single writer/reader: req 2 writes 0xA5 to 0x10, next cycle reads 0x10 -> req_ready[2] high both cycles. resp_valid=4'b0100 with resp_data=0xA5 one cycle after the read accept.
- Round-robin fairness: all 4 requesters hold reads to addresses 0x00..0x03, pre-written with 0x30..0x33, for 8 cycles -> grants 0,1,2,3,0,1,2,3. Responses 0x30,0x31,0x32,0x33 repeat one cycle behind, each with matching one-hot resp_valid.
- Pointer skip: only req 1 and 3 valid with rr_ptr=0 -> grant order 1,3,1,3. Then req 0 joins after grant to 3 -> it is granted next.
- Streaming: req 0 alone reads 0x00..0xFE back-to-back after writing data=addr -> 255 consecutive resp_valid cycles with resp_data=addr, no gaps.
- Reset mid-stream: assert rst on the edge after a read accept by req 1 -> no resp_valid appears. rr_ptr returns to 0 and requester 0 is granted first after release.
